// File: rtl/sort_pkg.sv
// Shared definitions for the streaming sort engine.
package sort_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/sort_ins_cell.sv
// One store position of the insertion sorter: picks its next entry from the upper
// neighbour, the incoming sample, or itself, and reports whether the new sample outranks it.
module sort_ins_cell #(
    parameter int W  = 8,
    parameter int IW = 2
) (
    input  logic [W-1:0]  own_data,
    input  logic [IW-1:0] own_idx,
    input  logic          own_valid,
    input  logic [W-1:0]  up_data,
    input  logic [IW-1:0] up_idx,
    input  logic          up_gt,
    input  logic [W-1:0]  new_data,
    input  logic [IW-1:0] new_idx,
    input  logic          ins_en,
    output logic [W-1:0]  next_data,
    output logic [IW-1:0] next_idx,
    output logic          gt
);

    // Strict compare keeps equal values in arrival order; an empty slot always loses.
    assign gt = !own_valid || (new_data > own_data);

    always_comb begin
        next_data = own_data;
        next_idx  = own_idx;
        if (ins_en) begin
            if (up_gt) begin
                next_data = up_data;
                next_idx  = up_idx;
            end else if (gt) begin
                next_data = new_data;
                next_idx  = new_idx;
            end
        end
    end

endmodule

// File: rtl/sort4_stream.sv
// Serial-in/serial-out descending sorter: insert N samples into a ranked store, then
// emit them largest-first with their arrival index.
module sort4_stream
    import sort_pkg::*;
#(
    parameter int  W  = 8,
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [IW-1:0] count_q, count_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  data_q [N];
    logic [W-1:0]  data_d [N];
    logic [IW-1:0] idx_q [N];
    logic [IW-1:0] idx_d [N];

    logic [W-1:0]  nxt_data [N];
    logic [IW-1:0] nxt_idx [N];
    logic          gt_w [N];
    logic          ins_en;
    logic          last_gt_unused;

    assign ins_en         = (state_q == ST_FILL) && in_valid;
    assign last_gt_unused = gt_w[N-1];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cell
            logic [W-1:0]  up_data;
            logic [IW-1:0] up_idx;
            logic          up_gt;
            if (gi == 0) begin : g_top
                assign up_data = '0;
                assign up_idx  = '0;
                assign up_gt   = 1'b0;
            end else begin : g_chain
                assign up_data = data_q[gi-1];
                assign up_idx  = idx_q[gi-1];
                assign up_gt   = gt_w[gi-1];
            end

            sort_ins_cell #(.W(W), .IW(IW)) u_cell (
                .own_data  (data_q[gi]),
                .own_idx   (idx_q[gi]),
                .own_valid (count_q > IW'(gi)),
                .up_data   (up_data),
                .up_idx    (up_idx),
                .up_gt     (up_gt),
                .new_data  (in_data),
                .new_idx   (count_q),
                .ins_en    (ins_en),
                .next_data (nxt_data[gi]),
                .next_idx  (nxt_idx[gi]),
                .gt        (gt_w[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        data_d  = nxt_data;
        idx_d   = nxt_idx;
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    if (count_q == IW'(N-1)) begin
                        count_d = '0;
                        state_d = ST_EMIT;
                    end else begin
                        count_d = count_q + IW'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (ptr_q == IW'(N-1)) begin
                        ptr_d   = '0;
                        state_d = ST_FILL;
                        for (int k = 0; k < N; k++) begin
                            data_d[k] = '0;
                            idx_d[k]  = '0;
                        end
                    end else begin
                        ptr_d = ptr_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            count_q <= '0;
            ptr_q   <= '0;
            for (int k = 0; k < N; k++) begin
                data_q[k] <= '0;
                idx_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            for (int k = 0; k < N; k++) begin
                data_q[k] <= data_d[k];
                idx_q[k]  <= idx_d[k];
            end
        end
    end

    assign in_ready  = (state_q == ST_FILL);
    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = out_valid ? data_q[ptr_q] : '0;
    assign out_idx   = out_valid ? idx_q[ptr_q] : '0;
    assign out_last  = out_valid && (ptr_q == IW'(N-1));
    assign busy      = (state_q == ST_EMIT) || (count_q != '0);

endmodule

// File: tb/tb_sort4_stream.sv
// Self-checking bench for sort4_stream: directed frames plus randomized frames against a
// rank-counting stable-sort model.
module tb_sort4_stream;

    typedef logic [7:0] frame_t [4];
    typedef logic [1:0] idxs_t [4];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sort4_stream #(.W(8), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Position of each sample = number of samples that must precede it in a stable descending sort.
    function automatic void model(input frame_t d, output frame_t ed, output idxs_t ei);
        for (int i = 0; i < 4; i++) begin
            int r;
            r = 0;
            for (int j = 0; j < 4; j++)
                if (d[j] > d[i] || (d[j] == d[i] && j < i)) r++;
            ed[r] = d[i];
            ei[r] = 2'(i);
        end
    endfunction

    task automatic send_frame(input frame_t d, input int vpct);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < 4) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                checks++;
                $display("FAIL send_timeout: accepted %0d samples, required 4", i);
                return;
            end
            checks++;
            if (in_ready !== 1'b1) $display("FAIL fill_in_ready: got %b required 1", in_ready);
            else passed++;
            in_valid = ($urandom_range(0, 99) >= vpct);
            in_data  = in_valid ? d[i] : 8'($urandom);
            if (in_valid && in_ready) i++;
        end
    endtask

    task automatic recv_frame(input frame_t d, input int rpct, input int stall_beat,
                              input int stall_len, input bit hold_in, input bit chk_lat,
                              input string tag);
        frame_t     ed;
        idxs_t      ei;
        int         beat;
        int         guard;
        int         stalled;
        bit         prev_hold;
        bit         first;
        logic [7:0] hd;
        logic [1:0] hi;
        logic       hl;
        model(d, ed, ei);
        beat = 0; guard = 0; stalled = 0; prev_hold = 0; first = 1;
        hd = '0; hi = '0; hl = 1'b0;
        while (beat < 4) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                checks++;
                $display("FAIL %s_timeout: got %0d beats, required 4", tag, beat);
                return;
            end
            in_valid = hold_in;
            in_data  = 8'($urandom);
            if (first && chk_lat) begin
                checks++;
                if (out_valid !== 1'b1) $display("FAIL %s_latency: out_valid %b required 1", tag, out_valid);
                else passed++;
            end
            first = 0;
            if (hold_in && out_valid === 1'b1) begin
                checks++;
                if (in_ready !== 1'b0) $display("FAIL %s_in_blocked: in_ready %b required 0", tag, in_ready);
                else passed++;
            end
            if (prev_hold) begin
                checks++;
                if ({out_data, out_idx, out_last} !== {hd, hi, hl})
                    $display("FAIL %s_hold: got %h/%0d/%b required %h/%0d/%b",
                             tag, out_data, out_idx, out_last, hd, hi, hl);
                else passed++;
            end
            if (beat == stall_beat && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = ($urandom_range(0, 99) >= rpct);
            end
            prev_hold = 0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    checks++;
                    if (out_data !== ed[beat]) $display("FAIL %s_data beat %0d: got %h required %h", tag, beat, out_data, ed[beat]);
                    else passed++;
                    checks++;
                    if (out_idx !== ei[beat]) $display("FAIL %s_idx beat %0d: got %0d required %0d", tag, beat, out_idx, ei[beat]);
                    else passed++;
                    checks++;
                    if (out_last !== (beat == 3)) $display("FAIL %s_last beat %0d: got %b required %b", tag, beat, out_last, beat == 3);
                    else passed++;
                    beat++;
                end else begin
                    prev_hold = 1;
                    hd = out_data; hi = out_idx; hl = out_last;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  $display("FAIL rst_in_ready: got %b required 1", in_ready);   else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else passed++;
        checks++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h required 00", out_data);  else passed++;
        checks++; if (out_idx !== 2'd0)   $display("FAIL rst_out_idx: got %0d required 0", out_idx);    else passed++;
        checks++; if (out_last !== 1'b0)  $display("FAIL rst_out_last: got %b required 0", out_last);   else passed++;
        checks++; if (busy !== 1'b0)      $display("FAIL rst_busy: got %b required 0", busy);           else passed++;
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        frame_t f;
        f = '{8'h10, 8'h40, 8'h20, 8'h30};
        send_frame(f, 0);
        recv_frame(f, 0, -1, 0, 1'b0, 1'b1, "basic");
        $display("test_basic done");
    endtask

    task automatic test_stable();
        frame_t f;
        f = '{8'h55, 8'h55, 8'h55, 8'h55};
        send_frame(f, 0);
        recv_frame(f, 0, -1, 0, 1'b0, 1'b1, "stable");
        $display("test_stable done");
    endtask

    task automatic test_stall();
        frame_t f;
        f = '{8'hFF, 8'h00, 8'h80, 8'h01};
        send_frame(f, 0);
        recv_frame(f, 0, 2, 5, 1'b0, 1'b1, "stall");
        $display("test_stall done");
    endtask

    task automatic test_in_during_emit();
        frame_t f;
        frame_t g;
        f = '{8'hA0, 8'h05, 8'hC1, 8'h03};
        g = '{8'd1, 8'd2, 8'd3, 8'd4};
        send_frame(f, 0);
        recv_frame(f, 30, -1, 0, 1'b1, 1'b1, "emit_block");
        send_frame(g, 0);
        recv_frame(g, 0, -1, 0, 1'b0, 1'b1, "after_block");
        $display("test_in_during_emit done");
    endtask

    task automatic test_reset_mid();
        frame_t f;
        f = '{8'd9, 8'd7, 8'd8, 8'd6};
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        in_data = 8'hDD;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b required 1", busy); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)     $display("FAIL mid_rst_busy: got %b required 0", busy);         else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b required 1", in_ready); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(f, 0);
        recv_frame(f, 0, -1, 0, 1'b0, 1'b1, "mid_rst");
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        frame_t f;
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 4; k++)
                f[k] = (n % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            send_frame(f, $urandom_range(0, 50));
            recv_frame(f, $urandom_range(0, 50), -1, 0, 1'b0, 1'b0, "rand");
        end
        $display("test_random done (1000 frames)");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stable();
        test_stall();
        test_in_during_emit();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
